// File: rtl/timer_loader.sv
// timer_loader: microwave-style m:ss keypad entry feeding the digit counters' parallel-load bus.
module timer_loader #(
  parameter logic [3:0] ENTER_CODE = 4'hA,
  parameter logic [3:0] CANCEL_CODE = 4'hB,
  parameter int MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_busy,
  output logic       loadn,
  output logic [3:0] min_data,
  output logic [2:0] tens_data,
  output logic [3:0] units_data,
  output logic       entry_active,
  output logic [1:0] digit_count,
  output logic       error
);
  typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;
  localparam logic [3:0] max_t = 4'(MAX_TENS);
  state_t state;
  logic [11:0] digits;
  logic [1:0] cnt;
  logic is_digit, enter, cancel;
  assign is_digit = key_valid && !timer_busy && key_code <= 4'd9;
  assign enter = key_valid && !timer_busy && key_code == ENTER_CODE;
  assign cancel = key_valid && key_code == CANCEL_CODE;
  always_ff @(posedge clk)
    if (clear) begin
      state <= IDLE;
      digits <= '0;
      cnt <= '0;
      loadn <= 1'b1;
      error <= 1'b0;
    end else begin
      loadn <= 1'b1;
      error <= 1'b0;
      case (state)
        IDLE:
          if (is_digit) begin
            digits <= {digits[7:0], key_code};
            cnt <= 2'd1;
            state <= ENTRY;
          end
        ENTRY:
          if (cancel) begin
            digits <= '0;
            cnt <= '0;
            state <= IDLE;
          end else if (is_digit && cnt != 2'd3) begin
            digits <= {digits[7:0], key_code};
            cnt <= cnt + 2'd1;
          end else if (enter && digits[7:4] <= max_t) begin
            loadn <= 1'b0;
            state <= LOAD;
          end else if (enter) begin
            digits <= '0;
            cnt <= '0;
            error <= 1'b1;
            state <= IDLE;
          end
        default: begin
          digits <= '0;
          cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  // the bus always mirrors the buffer; counters only sample it while loadn is low
  assign min_data = digits[11:8];
  assign tens_data = digits[6:4];
  assign units_data = digits[3:0];
  assign digit_count = cnt;
  assign entry_active = cnt != 2'd0;
endmodule

// File: tb/tb_timer_loader.sv
// tb_timer_loader: directed and random keypad traffic checked against a digit-queue model.
module tb_timer_loader;
  logic clk = 0, clear = 1, key_valid = 0, timer_busy = 0;
  logic [3:0] key_code = 0;
  logic loadn, entry_active, error;
  logic [3:0] min_data, units_data;
  logic [2:0] tens_data;
  logic [1:0] digit_count;
  int checks = 0, errors = 0;
  int q[$];
  bit m_load = 0, m_err = 0, armed = 0;

  timer_loader dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .timer_busy(timer_busy), .loadn(loadn), .min_data(min_data), .tens_data(tens_data),
    .units_data(units_data), .entry_active(entry_active), .digit_count(digit_count), .error(error)
  );

  always #5 clk = ~clk;

  function automatic int dig(int back);
    return q.size() > back ? q[q.size() - 1 - back] : 0;
  endfunction

  // inputs change 1 time unit after posedge, so at negedge they are what the next posedge samples
  always @(negedge clk) begin
    logic [15:0] act, exp;
    int t;
    if (armed) begin
      act = {loadn, min_data, tens_data, units_data, entry_active, digit_count, error};
      exp = {!m_load, 4'(dig(2)), 3'(dig(1)), 4'(dig(0)), q.size() != 0, 2'(q.size()), m_err};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_model @%0t: got %h expected %h", $time, act, exp);
      end
    end
    if (clear) begin
      q.delete(); m_load = 0; m_err = 0; armed = 1;
    end else if (m_load) begin
      q.delete(); m_load = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (key_valid) begin
        if (key_code == 4'hB) q.delete();
        else if (!timer_busy && key_code <= 4'd9 && q.size() < 3) q.push_back(int'(key_code));
        else if (!timer_busy && key_code == 4'hA && q.size() > 0) begin
          t = dig(1);
          if (t <= 5) m_load = 1;
          else begin q.delete(); m_err = 1; end
        end
      end
    end
  end

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic key(input logic [3:0] c);
    tick();
    key_valid = 1; key_code = c;
    tick();
    key_valid = 0;
  endtask

  task automatic chk_load(string n, int m, int t, int u);
    chk({n, "_loadn"}, loadn, 0);
    chk({n, "_min"}, min_data, m);
    chk({n, "_tens"}, tens_data, t);
    chk({n, "_units"}, units_data, u);
  endtask

  initial begin
    tick(); tick();
    clear = 0;
    chk("rst_loadn", loadn, 1);
    chk("rst_data", {min_data, tens_data, units_data}, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_active", entry_active, 0);
    chk("rst_error", error, 0);

    key(1); chk("d1_count", digit_count, 1);
    key(3); chk("d2_count", digit_count, 2);
    key(0); chk("d3_count", digit_count, 3);
    key(4'hA); chk_load("load130", 1, 3, 0);
    tick();
    chk("after130_loadn", loadn, 1);
    chk("after130_count", digit_count, 0);

    key(4); key(5); key(4'hA); chk_load("load045", 0, 4, 5);
    tick();

    key(1); key(7); key(5); key(4'hA);
    chk("bad175_error", error, 1);
    chk("bad175_loadn", loadn, 1);
    chk("bad175_count", digit_count, 0);
    tick();
    chk("bad175_error_gone", error, 0);

    key(2); key(5); key(9); key(8);
    chk("drop4th_count", digit_count, 3);
    chk("drop4th_units", units_data, 9);
    key(4'hA); chk_load("load259", 2, 5, 9);
    tick();

    key(3); key(4'hB);
    chk("cancel_count", digit_count, 0);
    chk("cancel_loadn", loadn, 1);

    key(1);
    timer_busy = 1;
    key(2); key(4'hA);
    chk("busy_count", digit_count, 1);
    chk("busy_loadn", loadn, 1);
    timer_busy = 0;
    key(4'hA); chk_load("load001", 0, 0, 1);
    tick();

    key(1); key(0);
    tick();
    key_valid = 1; key_code = 4'hA; clear = 1;
    tick();
    key_valid = 0; clear = 0;
    chk("clr_enter_loadn", loadn, 1);
    chk("clr_enter_count", digit_count, 0);
    chk("clr_enter_data", {min_data, tens_data, units_data}, 0);

    for (int i = 0; i < 4000; i++) begin
      int r;
      tick();
      r = $urandom_range(0, 19);
      key_valid = $urandom_range(0, 2) != 0;
      key_code = r < 10 ? 4'(r) : r < 14 ? 4'hA : r < 16 ? 4'hB : 4'(r - 4);
      if ($urandom_range(0, 24) == 0) timer_busy = ~timer_busy;
      clear = $urandom_range(0, 199) == 0;
    end
    tick();
    key_valid = 0; clear = 0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
